bar_tx: RTL and testbench
=========================

Name: bar_tx

Overview:
- Transmit end of the `bar` data/valid/ready interface.
- Drives a `bar.out` modport: data and valid are outputs, ready is an input. It is the counterpart of any consumer that takes `bar.in`.
- Producer logic pushes words into an internal FIFO; the block presents them on the interface under valid/ready flow control.
- Sits between a word source and `bar` consumers; one instance per interface instance.

Parameters:
- N, 32, data width in bits of `bar.data`; must be ≥1.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- wr_en  input  1  push request.
- wr_data  input  N  word to push.
- full  output  1  FIFO holds DEPTH entries; push not accepted.
- flush  input  1  discard all FIFO contents.
- overflow  output  1  sticky: a push was attempted while full.
- z  interface  bar.out  transmit port. Its members are:
  - z.data  output  N  current word.
  - z.valid  output  1  word present.
  - z.ready  input  1  consumer accepts.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers cleared; FSM goes to IDLE.
  - Outputs after reset: z.valid=0, z.data=0, full=0, overflow=0.
  - Reset mid-transfer drops the in-flight word unconditionally.
- FIFO:
  - wptr/rptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty when wptr==rptr.
  - full when the index bits are equal and the wrap bits differ.
  - full is combinational from the registered pointers.
- Push:
  - Accepted when wr_en && !full.
  - The word is written at wptr and wptr increments.
  - wr_en && full: word dropped, overflow set to 1. It stays 1 until rst.
  - A push in the same cycle as a pop while full is still rejected; full reflects the pre-edge state.
- Output stage: one register holds z.data and z.valid. FSM states and transitions:
  - IDLE: z.valid=0. If FIFO is non-empty, load head into z.data, increment rptr, go to SEND.
  - SEND: z.valid=1.
    - Transfer completes on a cycle with z.valid && z.ready.
    - On transfer, if FIFO non-empty, load the next head in the same edge and stay in SEND. This gives back-to-back throughput of one word per cycle.
    - On transfer with FIFO empty, go to IDLE (z.valid falls next cycle).
- Protocol rules:
  - While z.valid=1 and z.ready=0, z.data and z.valid hold stable. valid never deasserts without a transfer.
  - z.ready is ignored in IDLE.
  - z.valid does not depend combinationally on z.ready.
- Latency: push at edge t gives z.valid=1 after edge t+1 (two-cycle first-word latency). There is no bypass path.
- Flush:
  - Sets rptr=wptr on the edge and clears full.
  - The word already in the output stage (SEND) is not withdrawn; it completes normally, then the FSM returns to IDLE.
  - A push in the same cycle as flush is discarded. overflow is not affected.
- Ordering: words appear on z in push order; there is no duplication or loss except by overflow, flush, or rst.

Optional Feature:
- Macro: BAR_TX_STATS_EN.
- When defined, the block adds two outputs:
  - sent_cnt[31:0]: increments on each z.valid && z.ready.
  - stall_cnt[31:0]: increments on each cycle with z.valid && !z.ready.
  - Both counters wrap modulo 2^32 and reset to 0 on rst.
- When undefined, these ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Package `bar_pkg`:
  - typedef enum logic {IDLE, SEND} bar_tx_state_t.
  - localparam for default width 32.
  - function ptr_width(depth) returning $clog2(depth)+1.
- One sub-module `bar_fifo`, parameterised on N and DEPTH:
  - Contains the storage array, pointers, full/empty and flush.
  - Exposes push/pop/head/empty/full.
- bar_tx holds the output register, the FSM, overflow and the optional stats.

Test Plan:
- Reset, then idle 3 cycles → z.valid=0, full=0, overflow=0 every cycle.
- Push 0xA5 at cycle 0 with z.ready=1 held → z.valid=1 and z.data=0xA5 at cycle 2, z.valid=0 at cycle 3.
- Push 0x1,0x2,0x3 back-to-back with z.ready=0 for 5 cycles, then 1 → data stays 0x1 while stalled; then 0x1,0x2,0x3 on consecutive cycles; stall_cnt=5 when stats enabled.
- DEPTH=4, z.ready=0, push 6 words → full=1 after the fourth FIFO write (the first word moves into the output stage, so five pushes are accepted); sixth push dropped; overflow=1; drain yields exactly 5 words in order.
- Push 4 words, flush while SEND with head 0x1 and z.ready=0 → 0x1 held until ready, then z.valid=0; no further words.
- rst asserted while z.valid=1 and z.ready=0 → next cycle z.valid=0, FIFO empty, overflow=0.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared types and helpers for the bar transmit path.
package bar_pkg;

  localparam int BAR_DEF_WIDTH = 32;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} bar_tx_state_t;

  // Pointer width carries one extra wrap bit over the index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bar_if.sv
// The bar data/valid/ready interface; producers take out, consumers take in.
interface bar #(parameter int N = 32);
  logic [N-1:0] data;
  logic         valid;
  logic         ready;
  modport out (output data, output valid, input ready);
  modport in  (input data, input valid, output ready);
endinterface

// File: rtl/bar_fifo.sv
// Wrap-bit pointer FIFO feeding the bar_tx output stage; flush drops all contents.
module bar_fifo
  import bar_pkg::*;
#(
  parameter int N     = BAR_DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [N-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  logic [N-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic          push_s;
  logic          pop_s;

  // A flush in the same cycle wins over both push and pop.
  assign push_s = push && !full && !flush;
  assign pop_s  = pop && !empty && !flush;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[IW-1:0] == rptr_r[IW-1:0]) && (wptr_r[IW] != rptr_r[IW]);
  assign head  = mem_r[rptr_r[IW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_s) wptr_r <= wptr_r + PW'(1);
      if (flush)      rptr_r <= wptr_r;
      else if (pop_s) rptr_r <= rptr_r + PW'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bar_tx.sv
// Transmit end of the bar interface: FIFO plus registered valid/ready output stage.
// Optional BAR_TX_STATS_EN adds sent_cnt/stall_cnt counters.
module bar_tx
  import bar_pkg::*;
#(
  parameter int N     = BAR_DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  output logic         full,
  input  logic         flush,
  output logic         overflow,
  bar.out              z
`ifdef BAR_TX_STATS_EN
  ,
  output logic [31:0]  sent_cnt,
  output logic [31:0]  stall_cnt
`endif
);

  bar_tx_state_t state_r;
  bar_tx_state_t next_s;
  logic [N-1:0]  data_r;
  logic          valid_r;
  logic          overflow_r;
  logic [N-1:0]  head_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          xfer_s;

  bar_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop_s),
    .flush (flush),
    .head  (head_s),
    .empty (empty_s),
    .full  (full_s)
  );

  assign xfer_s   = valid_r && z.ready;
  assign full     = full_s;
  assign overflow = overflow_r;
  assign z.data   = data_r;
  assign z.valid  = valid_r;

  // Next-state and head-load decision; a flushing cycle never loads a new word.
  always_comb begin
    next_s = state_r;
    pop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !flush) begin
          pop_s  = 1'b1;
          next_s = SEND;
        end else begin
          next_s = IDLE;
        end
      end
      SEND: begin
        if (xfer_s) begin
          if (!empty_s && !flush) begin
            pop_s  = 1'b1;
            next_s = SEND;
          end else begin
            next_s = IDLE;
          end
        end else begin
          next_s = SEND;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Output register, FSM state and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      data_r     <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= next_s;
      valid_r <= (next_s == SEND);
      if (pop_s) data_r <= head_s;
      if (wr_en && full_s) overflow_r <= 1'b1;
    end
  end

`ifdef BAR_TX_STATS_EN
  // Transfer and stall counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (xfer_s) sent_cnt <= sent_cnt + 32'd1;
      if (valid_r && !z.ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bar_tx.sv
// Directed bench for bar_tx (N=32, DEPTH=4); checks stats when BAR_TX_STATS_EN is defined.
module tb_bar_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        flush;
  logic        overflow;
`ifdef BAR_TX_STATS_EN
  logic [31:0] sent_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bar #(.N(32)) z_if ();

  bar_tx #(.N(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .flush    (flush),
    .overflow (overflow),
    .z        (z_if)
`ifdef BAR_TX_STATS_EN
    ,
    .sent_cnt (sent_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 32'd0; flush = 1'b0; z_if.ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state and idle
    chk("rst_valid", {31'd0, z_if.valid}, 32'd0);
    chk("rst_data", z_if.data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", {31'd0, z_if.valid}, 32'd0);
      chk("idle_full", {31'd0, full}, 32'd0);
      chk("idle_ovf", {31'd0, overflow}, 32'd0);
    end

    // single word, two-cycle latency
    z_if.ready = 1'b1;
    push(32'hA5);
    chk("lat_v1", {31'd0, z_if.valid}, 32'd0);
    tick();
    chk("lat_v2", {31'd0, z_if.valid}, 32'd1);
    chk("lat_d2", z_if.data, 32'hA5);
    tick();
    chk("lat_v3", {31'd0, z_if.valid}, 32'd0);

    // stalled burst then back-to-back drain
    z_if.ready = 1'b0;
    push(32'h1);
    push(32'h2);
    chk("stall_v", {31'd0, z_if.valid}, 32'd1);
    push(32'h3);
    chk("stall_d0", z_if.data, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_d", z_if.data, 32'h1);
      chk("stall_vh", {31'd0, z_if.valid}, 32'd1);
    end
    z_if.ready = 1'b1;
    tick();
    chk("b2b_d2", z_if.data, 32'h2);
    tick();
    chk("b2b_d3", z_if.data, 32'h3);
    chk("b2b_v3", {31'd0, z_if.valid}, 32'd1);
    tick();
    chk("b2b_end", {31'd0, z_if.valid}, 32'd0);
`ifdef BAR_TX_STATS_EN
    chk("stall_cnt5", stall_cnt, 32'd5);
    chk("sent_cnt4", sent_cnt, 32'd4);
`endif

    // fill to full, overflow, drain five words in order
    z_if.ready = 1'b0;
    push(32'h11);
    push(32'h12);
    push(32'h13);
    push(32'h14);
    chk("fill_full4", {31'd0, full}, 32'd0);
    push(32'h15);
    chk("fill_full5", {31'd0, full}, 32'd1);
    chk("fill_ovf5", {31'd0, overflow}, 32'd0);
    push(32'h16);
    chk("fill_ovf6", {31'd0, overflow}, 32'd1);
    chk("fill_full6", {31'd0, full}, 32'd1);
    z_if.ready = 1'b1;
    wr_en = 1'b1; wr_data = 32'h99;   // rejected: full before the edge
    for (int i = 0; i < 5; i++) begin
      chk("drain_v", {31'd0, z_if.valid}, 32'd1);
      chk("drain_d", z_if.data, 32'h11 + i);
      tick();
      wr_en = 1'b0;
    end
    chk("drain_end", {31'd0, z_if.valid}, 32'd0);
    chk("drain_full", {31'd0, full}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
`ifdef BAR_TX_STATS_EN
    chk("sent_cnt9", sent_cnt, 32'd9);
    chk("stall_cnt9", stall_cnt, 32'd9);
`endif

    // flush while SEND holds 0x1
    z_if.ready = 1'b0;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    push(32'h4);
    flush = 1'b1; wr_en = 1'b1; wr_data = 32'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("fl_v", {31'd0, z_if.valid}, 32'd1);
    chk("fl_d", z_if.data, 32'h1);
    chk("fl_full", {31'd0, full}, 32'd0);
    tick(); tick();
    chk("fl_hold", z_if.data, 32'h1);
    z_if.ready = 1'b1;
    tick();
    chk("fl_done", {31'd0, z_if.valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_empty", {31'd0, z_if.valid}, 32'd0);
    end
    chk("fl_ovf", {31'd0, overflow}, 32'd1);

    // reset mid-transfer
    z_if.ready = 1'b0;
    push(32'h55);
    tick();
    chk("mr_v", {31'd0, z_if.valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_v0", {31'd0, z_if.valid}, 32'd0);
    chk("mr_d0", z_if.data, 32'd0);
    chk("mr_ovf", {31'd0, overflow}, 32'd0);
    tick(); tick();
    chk("mr_empty", {31'd0, z_if.valid}, 32'd0);
`ifdef BAR_TX_STATS_EN
    chk("mr_sent", sent_cnt, 32'd0);
    chk("mr_stall", stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
